mux_nx1_pipe: RTL
=================

Name: mux_nx1_pipe

Overview:
- Parametrised N-to-1 selector for FPU operand and result steering, W bits wide.
- Unlike a bare 2:1 mux, each input and the output carry a valid/ready handshake.
- Two arbitration modes: fixed select, or round-robin.
- Selected words land in a 2-entry skid buffer, giving 1-cycle latency at full throughput. Sits between operand sources and the FPU issue stage.

Parameters:
- NUM_IN, 4, number of input channels (>=2).
- WIDTH, 8, data bits per channel (>=1).
- SEL_W, $clog2(NUM_IN), width of select/source index (derived; not overridden).
- CNT_W, 16, width of transfer counter (optional feature only).

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous, active-high reset.
- in_data  in  NUM_IN*WIDTH  channel i at bits [i*WIDTH +: WIDTH].
- in_valid  in  NUM_IN  per-channel valid.
- in_ready  out  NUM_IN  per-channel ready (one-hot or zero).
- sel  in  SEL_W  channel index, fixed mode.
- rr_mode  in  1  0 = fixed select, 1 = round-robin.
- out_data  out  WIDTH  selected word, head of buffer.
- out_src  out  SEL_W  channel index the head word came from.
- out_valid  out  1  head word present.
- out_ready  in  1  downstream accepts.

Behaviour:
- Single clock domain: clk. Reset is synchronous, active-high, on rst.
- Reset values:
  - count=0, out_valid=0, out_data=0, out_src=0, rr_ptr=0.
  - Both buffer entries are cleared.
- Reset mid-operation discards buffered words. in_ready is 0 during the reset cycle.
- Grant, computed combinationally each cycle:
  - Fixed mode: grant=sel if in_valid[sel]. If sel>=NUM_IN, there is no grant.
  - Round-robin mode: grant is the first i with in_valid[i], scanning rr_ptr, rr_ptr+1, ... modulo NUM_IN.
- in_ready:
  - in_ready[grant]=1 when count<2; all other bits are 0.
  - With no grant, in_ready=0.
  - in_ready may depend on in_valid, sel and rr_mode; it never depends on out_ready.
- Push: in_valid[grant] and in_ready[grant] are both high. At most one push per cycle.
- rr_ptr:
  - Round-robin mode: on a push, rr_ptr <= (grant+1) mod NUM_IN. The wrap from NUM_IN-1 goes to 0.
  - Fixed mode: rr_ptr holds.
- Pop: out_valid and out_ready are both high.
- Buffer: a 2-entry FIFO of {src, data}. count takes values 0, 1 or 2.
  - Push only: count+1. Pop only: count-1. Push and pop together: count unchanged.
  - At count=2, push is impossible, so only a pop can occur.
  - At count=0, pop is impossible.
- Latency: a word pushed in cycle t appears on out_data/out_valid in cycle t+1, even when count was 0.
- Throughput: sustained 1 word/cycle when out_ready is held at 1.
- Stall: while out_valid=1 and out_ready=0, out_data and out_src are held stable.
- Mode switch or sel change takes effect in the same cycle. Words already buffered are unaffected.
- Order: output order equals push order. No data is reordered or dropped.

Optional Feature:
- Macro MUX_PIPE_XFER_CNT_EN.
- Defined:
  - Adds output port xfer_cnt [CNT_W].
  - The counter increments on every pop and wraps 2^CNT_W-1 -> 0.
  - It is reset to 0 by rst.
  - A simultaneous push does not affect it.
- Undefined: the port and counter are absent. All other behaviour is identical.

Decomposition:
- Package mux_pipe_pkg holds:
  - typedef for buffer count (2-bit);
  - localparam BUF_DEPTH=2;
  - function next_rr(ptr, n) implementing the modulo increment.
- Sub-module mux_pipe_skid: the 2-entry {src, data} FIFO with push/pop/count. It is reused elsewhere in the FPU pipeline.
- Top level holds grant logic, rr_ptr and the optional counter.

Test Plan (NUM_IN=4, WIDTH=8):
- Reset then idle: hold rst 2 cycles, then release with all in_valid=0 -> out_valid=0, out_data=0x00, in_ready=4'b0000.
- Fixed mode, sel=2, in_valid=4'b1111, in_data ch2=0xA5, out_ready=1 -> in_ready=4'b0100; next cycle out_data=0xA5, out_src=2, out_valid=1. Then sel=3'd... sel=4 is unrepresentable, so drive sel=1 with in_valid[1]=0 -> in_ready=0.
- Round-robin fairness: rr_mode=1, all valid, out_ready=1 for 8 cycles -> out_src sequence 0,1,2,3,0,1,2,3 (wrap 3->0).
- Backpressure: fixed sel=0, in_valid=1, out_ready=0, words 0x11, 0x22, 0x33 offered:
  - after 2 pushes, in_ready[0]=0 and 0x33 is held off;
  - out_data stays 0x11;
  - raising out_ready pops 0x11, then 0x22, then 0x33 in order.
- Simultaneous push/pop at count=1 for 10 cycles -> count stays 1, 10 words out in order, no bubbles.
- Reset mid-stream: count=2, assert rst -> next cycle out_valid=0 and rr_ptr=0. With MUX_PIPE_XFER_CNT_EN and CNT_W=4, after 17 pops from reset xfer_cnt=1.

Source files
------------

// File: rtl/mux_pipe_pkg.sv
// Shared types and helpers for the N:1 pipelined selector and its skid buffer.
package mux_pipe_pkg;

  localparam int unsigned BUF_DEPTH = 2;

  typedef logic [1:0] buf_cnt_t;

  // Modulo-n increment used to advance the round-robin pointer.
  function automatic int unsigned next_rr(input int unsigned ptr, input int unsigned n);
    return (ptr + 1 >= n) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/mux_pipe_skid.sv
// Two-entry {src, data} FIFO: registered head gives one-cycle latency at full throughput.
module mux_pipe_skid
  import mux_pipe_pkg::*;
#(
  parameter int unsigned DW = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push,
  input  logic [DW-1:0] push_word,
  input  logic          pop,
  output logic [DW-1:0] head,
  output logic          head_valid,
  output buf_cnt_t      count
);

  logic [DW-1:0] ent0_q, ent1_q;
  buf_cnt_t      cnt_q;
  logic          do_push, do_pop;

  // Illegal requests (push when full, pop when empty) are ignored.
  assign do_push = push && (cnt_q != buf_cnt_t'(BUF_DEPTH));
  assign do_pop  = pop && (cnt_q != 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      ent0_q <= '0;
      ent1_q <= '0;
      cnt_q  <= 2'd0;
    end else begin
      case ({do_push, do_pop})
        2'b10: begin
          if (cnt_q == 2'd0) ent0_q <= push_word;
          else               ent1_q <= push_word;
          cnt_q <= cnt_q + 2'd1;
        end
        2'b01: begin
          ent0_q <= ent1_q;
          cnt_q  <= cnt_q - 2'd1;
        end
        // Both legal together only at count 1: the new word replaces the departing head.
        2'b11:   ent0_q <= push_word;
        default: ;
      endcase
    end
  end

  assign head       = ent0_q;
  assign head_valid = (cnt_q != 2'd0);
  assign count      = cnt_q;

endmodule

// File: rtl/mux_nx1_pipe.sv
// N:1 valid/ready selector (fixed or round-robin) feeding a 2-entry skid buffer.
// Optional transfer counter port xfer_cnt enabled by MUX_PIPE_XFER_CNT_EN.
module mux_nx1_pipe
  import mux_pipe_pkg::*;
#(
  parameter int unsigned NUM_IN = 4,
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned SEL_W  = $clog2(NUM_IN)
`ifdef MUX_PIPE_XFER_CNT_EN
  ,
  parameter int unsigned CNT_W  = 16
`endif
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [NUM_IN-1:0]       in_valid,
  output logic [NUM_IN-1:0]       in_ready,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    rr_mode,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_src,
  output logic                    out_valid,
  input  logic                    out_ready
`ifdef MUX_PIPE_XFER_CNT_EN
  ,
  output logic [CNT_W-1:0]        xfer_cnt
`endif
);

  logic [SEL_W-1:0]       rr_ptr_q;
  logic [SEL_W-1:0]       grant;
  logic                   grant_vld;
  logic                   push, pop;
  buf_cnt_t               count;
  logic [SEL_W+WIDTH-1:0] push_word, head;

  always_comb begin
    int unsigned idx;
    grant     = '0;
    grant_vld = 1'b0;
    idx       = 0;
    if (!rr_mode) begin
      if ((32'(sel) < NUM_IN) && in_valid[sel]) begin
        grant     = sel;
        grant_vld = 1'b1;
      end
    end else begin
      for (int unsigned k = 0; k < NUM_IN; k++) begin
        idx = (32'(rr_ptr_q) + k) % NUM_IN;
        if (!grant_vld && in_valid[idx]) begin
          grant     = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  // Readiness never looks at out_ready, so no combinational path runs upstream from it.
  assign push = grant_vld && !rst && (count != buf_cnt_t'(BUF_DEPTH));
  assign pop  = out_valid && out_ready;

  always_comb begin
    in_ready        = '0;
    in_ready[grant] = push;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q <= '0;
    end else if (push && rr_mode) begin
      rr_ptr_q <= SEL_W'(next_rr(32'(grant), NUM_IN));
    end
  end

  assign push_word = {grant, in_data[32'(grant)*WIDTH +: WIDTH]};

  mux_pipe_skid #(
    .DW(SEL_W + WIDTH)
  ) u_skid (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_word (push_word),
    .pop       (pop),
    .head      (head),
    .head_valid(out_valid),
    .count     (count)
  );

  assign out_data = head[WIDTH-1:0];
  assign out_src  = head[WIDTH +: SEL_W];

`ifdef MUX_PIPE_XFER_CNT_EN
  logic [CNT_W-1:0] xfer_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)      xfer_cnt_q <= '0;
    else if (pop) xfer_cnt_q <= xfer_cnt_q + 1'b1;
  end

  assign xfer_cnt = xfer_cnt_q;
`endif

endmodule
